hazard_forward_ctrl: RTL

- Sequences the decode stage of the 16-bit pipeline: tracks in-flight destination registers through EX, MEM and WB, and drives the ForwardA/ForwardB operand selects and the stall line.
- Sits beside the decode stage. Consumes decoded source/destination fields and a branch flush, and keeps a 3-slot shadow scoreboard of the pipeline.
- Also maintains saturating stall and flush event counters for performance debug.

---
 rtl/hazard_forward_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hazard_forward_ctrl.sv
// Decode-side hazard unit: shadows the EX/MEM/WB destinations to pick operand forwarding
// sources, raises a one-cycle load-use stall, and keeps saturating stall/flush counters.
module hazard_forward_ctrl #(
  parameter int unsigned REG_W   = 3,
  parameter int unsigned CNT_W   = 16,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_writes,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             stall,
  output logic             ex_busy,
  output logic             mem_busy,
  output logic             wb_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } ex_slot_t;

  // The load flag only matters while the producer sits in EX, so later slots drop it.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wr;
  } slot_t;

  ex_slot_t ex_q, ex_d;
  slot_t    mem_q, wb_q;

  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic a_ex, a_mem, a_wb;
  logic b_ex, b_mem, b_wb;
  logic stall_int, flush_evt;

  function automatic logic src_match(input logic             v,
                                     input logic             wr,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] src,
                                     input logic             use_src,
                                     input logic             valid);
    logic hit;
    hit = v & wr & (rd == src) & use_src & valid;
    if (R0_ZERO && (src == '0)) hit = 1'b0;
    return hit;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m, input logic wb_m);
    logic [1:0] sel;
    if (ex_m)       sel = 2'd1;
    else if (mem_m) sel = 2'd2;
    else if (wb_m)  sel = 2'd3;
    else            sel = 2'd0;
    return sel;
  endfunction

  always_comb begin
    a_ex  = src_match(ex_q.v,  ex_q.wr,  ex_q.rd,  id_ra, id_uses_a, id_valid);
    a_mem = src_match(mem_q.v, mem_q.wr, mem_q.rd, id_ra, id_uses_a, id_valid);
    a_wb  = src_match(wb_q.v,  wb_q.wr,  wb_q.rd,  id_ra, id_uses_a, id_valid);
    b_ex  = src_match(ex_q.v,  ex_q.wr,  ex_q.rd,  id_rb, id_uses_b, id_valid);
    b_mem = src_match(mem_q.v, mem_q.wr, mem_q.rd, id_rb, id_uses_b, id_valid);
    b_wb  = src_match(wb_q.v,  wb_q.wr,  wb_q.rd,  id_rb, id_uses_b, id_valid);

    // Flush outranks the load-use hazard; reset silences every output.
    stall_int = (a_ex | b_ex) & ex_q.ld & id_valid & ~flush & ~reset;
    flush_evt = flush & id_valid & ~reset;

    ForwardA = reset ? 2'd0 : fwd_sel(a_ex, a_mem, a_wb);
    ForwardB = reset ? 2'd0 : fwd_sel(b_ex, b_mem, b_wb);
    stall    = stall_int;
    ex_busy  = ~reset & ex_q.v & ex_q.wr;
    mem_busy = ~reset & mem_q.v & mem_q.wr;
    wb_busy  = ~reset & wb_q.v & wb_q.wr;

    ex_d = '0;
    if (id_valid && !stall_int && !flush) begin
      ex_d = '{v: 1'b1, rd: id_rd, wr: id_writes, ld: id_is_load};
    end

    stall_count_d = stall_count_q;
    if (stall_int && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
    flush_count_d = flush_count_q;
    if (flush_evt && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= '{v: ex_q.v, rd: ex_q.rd, wr: ex_q.wr};
      wb_q          <= mem_q;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

endmodule
